fp_mantissa_multiplier: RTL and testbench

//  Sequential front end of the single-precision FPU multiplier. Unpacks two IEEE-754 binary32

---
 rtl/fp_mantissa_multiplier_if.sv | 29 ++
 rtl/fp_mantissa_multiplier.sv | 161 ++++++++++++++++
 tb/tb_fp_mantissa_multiplier.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/fp_mantissa_multiplier_if.sv
// Operand/result handshake bundle between the FPU multiplier front end and its neighbours.
// The slave modport is the multiplier side; master is the producer/consumer side.
interface fp_mantissa_multiplier_if #(
    parameter int unsigned MANT_W = 24,
    parameter int unsigned EXP_W  = 8
);
    logic              in_valid;
    logic              in_ready;
    logic [31:0]       op_a;
    logic [31:0]       op_b;
    logic              out_valid;
    logic              out_ready;
    logic              sign;
    logic [EXP_W-1:0]  exponent;
    logic [MANT_W-1:0] fraction;
    logic              zero;
    logic              exp_ovf;
    logic              exp_unf;

    modport slave (
        input  in_valid, op_a, op_b, out_ready,
        output in_ready, out_valid, sign, exponent, fraction, zero, exp_ovf, exp_unf
    );

    modport master (
        output in_valid, op_a, op_b, out_ready,
        input  in_ready, out_valid, sign, exponent, fraction, zero, exp_ovf, exp_unf
    );
endinterface

// File: rtl/fp_mantissa_multiplier.sv
// Sequential shift-add front end of the binary32 multiplier: sign, biased exponent sum, and
// upper half of the 24x24 mantissa product. Optional macro ZERO_BYPASS_EN short-cuts zero operands.
module fp_mantissa_multiplier #(
    parameter int unsigned MANT_W = 24,
    parameter int unsigned EXP_W  = 8,
    parameter int unsigned BIAS   = 127
) (
    input logic                     clk,
    input logic                     rst_n,
    fp_mantissa_multiplier_if.slave s_bus
);
    localparam int unsigned PROD_W = 2 * MANT_W;
    localparam int unsigned FRAC_W = MANT_W - 1;
    localparam int unsigned SUM_W  = EXP_W + 2;
    localparam int unsigned CNT_W  = 5;

    localparam logic [SUM_W-1:0] EXP_MAX  = SUM_W'((1 << EXP_W) - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MANT_W - 1);

    typedef enum logic [1:0] {StIdle, StMul, StDone} state_e;

    state_e r_state;
    state_e w_state_d;

    logic              w_in_ready;
    logic              w_out_valid;
    logic              w_accept;
    logic              w_to_done;

    logic [EXP_W-1:0]  w_ea;
    logic [EXP_W-1:0]  w_eb;
    logic [MANT_W-1:0] w_ma;
    logic [MANT_W-1:0] w_mb;
    logic [SUM_W-1:0]  w_exp_sum;
    logic [PROD_W-1:0] w_acc_next;

    logic              r_sign_op;
    logic              r_zero_op;
    logic [SUM_W-1:0]  r_exp_sum;
    logic [PROD_W-1:0] r_mcand;
    logic [MANT_W-1:0] r_mplr;
    logic [PROD_W-1:0] r_acc;
    logic [CNT_W-1:0]  r_cnt;

    logic              r_sign;
    logic [EXP_W-1:0]  r_exponent;
    logic [MANT_W-1:0] r_fraction;
    logic              r_zero;
    logic              r_exp_ovf;
    logic              r_exp_unf;

    // Unpack; a zero exponent field clears the hidden bit.
    assign w_ea      = s_bus.op_a[FRAC_W +: EXP_W];
    assign w_eb      = s_bus.op_b[FRAC_W +: EXP_W];
    assign w_ma      = {|w_ea, s_bus.op_a[FRAC_W-1:0]};
    assign w_mb      = {|w_eb, s_bus.op_b[FRAC_W-1:0]};
    assign w_exp_sum = SUM_W'(w_ea) + SUM_W'(w_eb) - SUM_W'(BIAS);

    assign w_accept   = s_bus.in_valid & w_in_ready;
    assign w_acc_next = r_mplr[0] ? (r_acc + r_mcand) : r_acc;
    assign w_to_done  = (r_state == StMul) && (w_state_d == StDone);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_d;
        end
    end

    always_comb begin
        w_state_d = r_state;
        unique case (r_state)
            StIdle: begin
                if (w_accept) begin
                    w_state_d = StMul;
                end
            end
            StMul: begin
`ifdef ZERO_BYPASS_EN
                // Zero operands leave after the first MUL cycle, so out_valid follows accept by one.
                if (r_zero_op || (r_cnt == CNT_LAST)) begin
                    w_state_d = StDone;
                end
`else
                if (r_cnt == CNT_LAST) begin
                    w_state_d = StDone;
                end
`endif
            end
            StDone: begin
                if (s_bus.out_ready) begin
                    w_state_d = StIdle;
                end
            end
            default: w_state_d = StIdle;
        endcase
    end

    always_comb begin
        w_in_ready  = 1'b0;
        w_out_valid = 1'b0;
        unique case (r_state)
            StIdle:  w_in_ready  = 1'b1;
            StDone:  w_out_valid = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sign_op  <= 1'b0;
            r_zero_op  <= 1'b0;
            r_exp_sum  <= '0;
            r_mcand    <= '0;
            r_mplr     <= '0;
            r_acc      <= '0;
            r_cnt      <= '0;
            r_sign     <= 1'b0;
            r_exponent <= '0;
            r_fraction <= '0;
            r_zero     <= 1'b0;
            r_exp_ovf  <= 1'b0;
            r_exp_unf  <= 1'b0;
        end else begin
            if (w_accept) begin
                r_sign_op <= s_bus.op_a[31] ^ s_bus.op_b[31];
                r_zero_op <= (w_ea == '0) || (w_eb == '0);
                r_exp_sum <= w_exp_sum;
                r_mcand   <= PROD_W'(w_ma);
                r_mplr    <= w_mb;
                r_acc     <= '0;
                r_cnt     <= '0;
            end else if (r_state == StMul) begin
                r_acc   <= w_acc_next;
                r_mcand <= r_mcand << 1;
                r_mplr  <= r_mplr >> 1;
                r_cnt   <= r_cnt + CNT_W'(1);
            end

            // Result registers load once on entry to DONE and hold until the next result.
            if (w_to_done) begin
                r_sign     <= r_sign_op;
                r_zero     <= r_zero_op;
                r_fraction <= r_zero_op ? '0 : w_acc_next[PROD_W-1:MANT_W];
                r_exponent <= r_zero_op ? '0 : r_exp_sum[EXP_W-1:0];
                r_exp_ovf  <= !r_zero_op && ($signed(r_exp_sum) >= $signed(EXP_MAX));
                r_exp_unf  <= !r_zero_op && (r_exp_sum[SUM_W-1] || (r_exp_sum == '0));
            end
        end
    end

    assign s_bus.in_ready  = w_in_ready;
    assign s_bus.out_valid = w_out_valid;
    assign s_bus.sign      = r_sign;
    assign s_bus.exponent  = r_exponent;
    assign s_bus.fraction  = r_fraction;
    assign s_bus.zero      = r_zero;
    assign s_bus.exp_ovf   = r_exp_ovf;
    assign s_bus.exp_unf   = r_exp_unf;
endmodule

// File: tb/tb_fp_mantissa_multiplier.sv
// Directed plus randomized bench for fp_mantissa_multiplier against an arithmetic reference model.
module tb_fp_mantissa_multiplier;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_tests = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    fp_mantissa_multiplier_if bus ();

    fp_mantissa_multiplier dut (
        .clk   (clk),
        .rst_n (rst_n),
        .s_bus (bus)
    );

    typedef struct {
        int unsigned sign;
        int unsigned exponent;
        int unsigned fraction;
        int unsigned zero;
        int unsigned ovf;
        int unsigned unf;
    } res_t;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: real-number rules for binary32 operands, product kept as a 64-bit integer.
    function automatic res_t model(input logic [31:0] a, input logic [31:0] b);
        res_t        r;
        int          ea;
        int          eb;
        int          sum;
        longint      ma;
        longint      mb;
        longint      prod;
        ea   = int'(a[30:23]);
        eb   = int'(b[30:23]);
        ma   = longint'(a[22:0]) + ((ea != 0) ? 64'd8388608 : 64'd0);
        mb   = longint'(b[22:0]) + ((eb != 0) ? 64'd8388608 : 64'd0);
        prod = ma * mb;
        sum  = ea + eb - 127;
        r.sign = a[31] ^ b[31];
        r.zero = (ea == 0 || eb == 0) ? 1 : 0;
        if (r.zero != 0) begin
            r.exponent = 0;
            r.fraction = 0;
            r.ovf      = 0;
            r.unf      = 0;
        end else begin
            r.exponent = sum & 255;
            r.fraction = int'(prod / 64'd16777216) & 32'hFFFFFF;
            r.ovf      = (sum >= 255) ? 1 : 0;
            r.unf      = (sum <= 0) ? 1 : 0;
        end
        return r;
    endfunction

    task automatic check_result(input string tag, input res_t e);
        check({tag, ".sign"},     64'(bus.sign),     64'(e.sign));
        check({tag, ".exponent"}, 64'(bus.exponent), 64'(e.exponent));
        check({tag, ".fraction"}, 64'(bus.fraction), 64'(e.fraction));
        check({tag, ".zero"},     64'(bus.zero),     64'(e.zero));
        check({tag, ".exp_ovf"},  64'(bus.exp_ovf),  64'(e.ovf));
        check({tag, ".exp_unf"},  64'(bus.exp_unf),  64'(e.unf));
    endtask

    // Called #1 after a rising edge with the DUT idle; returns in the same phase, DUT idle again.
    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input bit hold);
        res_t e;
        int   lat;
        int   exp_lat;
        e = model(a, b);
`ifdef ZERO_BYPASS_EN
        exp_lat = (e.zero != 0) ? 1 : 24;
`else
        exp_lat = 24;
`endif
        check({tag, ".in_ready_idle"}, 64'(bus.in_ready), 64'd1);
        bus.op_a      = a;
        bus.op_b      = b;
        bus.in_valid  = 1'b1;
        bus.out_ready = !hold;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        lat = 0;
        while (bus.out_valid !== 1'b1 && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check({tag, ".latency"}, 64'(lat), 64'(exp_lat));
        check({tag, ".in_ready_busy"}, 64'(bus.in_ready), 64'd0);
        check_result(tag, e);
        if (hold) begin
            repeat (5) begin
                bus.in_valid = 1'b1;
                bus.op_a     = $urandom;
                bus.op_b     = $urandom;
                @(posedge clk);
                #1;
                check({tag, ".hold_valid"}, 64'(bus.out_valid), 64'd1);
                check({tag, ".hold_in_ready"}, 64'(bus.in_ready), 64'd0);
                check_result({tag, ".hold"}, e);
            end
            bus.in_valid  = 1'b0;
            bus.out_ready = 1'b1;
        end
        @(posedge clk);
        #1;
        check({tag, ".post_valid"}, 64'(bus.out_valid), 64'd0);
        check({tag, ".post_in_ready"}, 64'(bus.in_ready), 64'd1);
    endtask

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        bus.op_a      = '0;
        bus.op_b      = '0;

        #2;
        check("rst.in_ready",  64'(bus.in_ready),  64'd1);
        check("rst.out_valid", 64'(bus.out_valid), 64'd0);
        check("rst.sign",      64'(bus.sign),      64'd0);
        check("rst.exponent",  64'(bus.exponent),  64'd0);
        check("rst.fraction",  64'(bus.fraction),  64'd0);
        check("rst.zero",      64'(bus.zero),      64'd0);
        check("rst.exp_ovf",   64'(bus.exp_ovf),   64'd0);
        check("rst.exp_unf",   64'(bus.exp_unf),   64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        run_op("one_x_one", 32'h3F800000, 32'h3F800000, 1'b0);
        check("one_x_one.frac_const", 64'(bus.fraction), 64'h400000);
        run_op("p15_x_p15", 32'h3FC00000, 32'h3FC00000, 1'b0);
        check("p15_x_p15.frac_const", 64'(bus.fraction), 64'h900000);
        run_op("m2_x_p3",   32'hC0000000, 32'h40400000, 1'b0);
        check("m2_x_p3.exp_const", 64'(bus.exponent), 64'h81);
        run_op("zero_op",   32'h00000000, 32'h3F800000, 1'b0);
        run_op("neg_zero",  32'h80000000, 32'h3F800000, 1'b0);
        run_op("denorm_op", 32'h00400000, 32'h3F800000, 1'b0);
        run_op("ovf",       32'h7F000000, 32'h7F000000, 1'b0);
        check("ovf.flag_const", 64'(bus.exp_ovf), 64'd1);
        run_op("inf_nan",   32'h7F800001, 32'h3F800000, 1'b0);
        run_op("unf",       32'h00800000, 32'h00800000, 1'b0);
        check("unf.flag_const", 64'(bus.exp_unf), 64'd1);
        run_op("unf_edge",  32'h3F000000, 32'h00800000, 1'b0);
        run_op("max_mant",  32'h3FFFFFFF, 32'h3FFFFFFF, 1'b0);
        run_op("hold",      32'hC0400000, 32'h40A00000, 1'b1);

        // Reset mid-multiply: abort at iteration 10, then a clean 1.0 * 1.0.
        bus.op_a     = 32'h3FC00000;
        bus.op_b     = 32'h40000000;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("abort.out_valid", 64'(bus.out_valid), 64'd0);
        check("abort.in_ready",  64'(bus.in_ready),  64'd1);
        check("abort.fraction",  64'(bus.fraction),  64'd0);
        check("abort.exponent",  64'(bus.exponent),  64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        run_op("after_abort", 32'h3F800000, 32'h3F800000, 1'b0);

        for (int i = 0; i < 20; i++) begin
            ra = $urandom;
            rb = $urandom;
            if ($urandom_range(0, 4) == 0) ra[30:23] = 8'h00;
            if ($urandom_range(0, 4) == 0) rb[30:23] = 8'h00;
            if ($urandom_range(0, 5) == 0) rb[30:23] = 8'hFF;
            run_op("random", ra, rb, ($urandom_range(0, 5) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
